vote_monitor: RTL

VOTE_MONITOR -- requirements
Module: vote_monitor

---
 rtl/vote_pkg.sv | 15 +
 rtl/vote_debounce.sv | 90 +++++++++
 rtl/vote_monitor.sv | 73 +++++++
 3 files changed

// File: rtl/vote_pkg.sv
// Shared types and constants for the vote monitor: FSM states, majority
// threshold and error-flag bit positions.
package vote_pkg;

  typedef enum logic [1:0] {IDLE, STABLE, FILTER} state_t;

  localparam int unsigned MAJ_THRESH = 3;
  localparam int unsigned ERR_SOMIN  = 0;
  localparam int unsigned ERR_POMAX  = 1;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/vote_debounce.sv
// Debounce FSM: pass follows raw only after DEB_CYCLES consecutive enabled
// samples disagree with it; reports each confirmed 0->1 toggle.
module vote_debounce
  import vote_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  input  logic raw_i,
  output logic pass_o,
  output logic busy_o,
  output logic rise_o
);

  localparam logic [4:0] DebLim = 5'(DEB_CYCLES);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       pass_q, pass_d;
  logic       busy_q;
  logic [4:0] cnt_inc;

  assign cnt_inc = {1'b0, cnt_q} + 5'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    rise_o  = 1'b0;
    if (clr_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      pass_d  = 1'b0;
    end else if (en_i) begin
      unique case (state_q)
        IDLE: begin
          pass_d  = raw_i;
          state_d = STABLE;
        end
        STABLE: begin
          if (raw_i != pass_q) begin
            if (DebLim == 5'd1) begin
              pass_d = raw_i;
              rise_o = raw_i;
            end else begin
              state_d = FILTER;
              cnt_d   = 4'd1;
            end
          end
        end
        FILTER: begin
          if (raw_i == pass_q) begin
            // Glitch shorter than the debounce window: drop it.
            cnt_d   = '0;
            state_d = STABLE;
          end else if (cnt_inc == DebLim) begin
            pass_d  = raw_i;
            rise_o  = raw_i;
            cnt_d   = '0;
            state_d = STABLE;
          end else begin
            cnt_d = cnt_inc[3:0];
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      busy_q  <= (state_d == FILTER);
    end
  end

  assign pass_o = pass_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/vote_monitor.sv
// Majority-vote monitor: cross-checks upstream SOP/POS results against a
// golden popcount, debounces the SOP result and counts confirmed rises.
module vote_monitor
  import vote_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [3:0]       abcd,
  input  logic             somin,
  input  logic             pomax,
  output logic             pass,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [1:0]       err_code,
  output logic             err,
  output logic             busy
);

  logic             golden;
  logic             rise;
  logic [1:0]       err_code_q, err_code_d;
  logic             err_q;
  logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;

  assign golden = (popcount4(abcd) >= 3'(MAJ_THRESH));

  vote_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .en_i  (en),
    .clr_i (clr),
    .raw_i (somin),
    .pass_o(pass),
    .busy_o(busy),
    .rise_o(rise)
  );

  always_comb begin
    err_code_d = err_code_q;
    rise_cnt_d = rise_cnt_q;
    if (clr) begin
      err_code_d = '0;
      rise_cnt_d = '0;
    end else if (en) begin
      err_code_d[ERR_SOMIN] = err_code_q[ERR_SOMIN] | (somin != golden);
      err_code_d[ERR_POMAX] = err_code_q[ERR_POMAX] | (pomax != golden);
      if (rise && (rise_cnt_q != '1)) rise_cnt_d = rise_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_code_q <= '0;
      err_q      <= 1'b0;
      rise_cnt_q <= '0;
    end else begin
      err_code_q <= err_code_d;
      err_q      <= |err_code_d;
      rise_cnt_q <= rise_cnt_d;
    end
  end

  assign err_code = err_code_q;
  assign err      = err_q;
  assign rise_cnt = rise_cnt_q;

endmodule
